// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg -- shared types and sizes for the mux scan sampler.
//   state_t : scan FSM state encoding (2 bits)
//   SEL_W   : width of the downstream mux select
//   NUM_CH  : number of mux channels scanned per request
//   CNT_W   : width of the settle counter
package mux_scan_pkg;

    localparam int SEL_W  = 2;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mux_scan_settle_ctr.sv
// mux_scan_settle_ctr -- settle-time counter for the mux scan sampler.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : clear the count (a new settle period starts next clock)
//   en         : advance the count by one
//   tc         : count has reached SETTLE_CYCLES-1, i.e. this is the last
//                settle clock
module mux_scan_settle_ctr
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == LAST);

endmodule

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler -- scans a downstream 4-to-1 mux one channel at a time,
// waiting SETTLE_CYCLES clocks after each select change before sampling,
// and presents the four samples as one word with a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request one scan (honoured in IDLE, or in DONE with ready)
//   sel        : select driven to the mux
//   mux_out    : mux output being sampled
//   word       : scan result, word[i] sampled with sel==i
//   valid      : word holds a completed scan (high exactly in DONE)
//   ready      : consumer accepts word
//   busy       : high in every state except IDLE
//   parity     : ^word, only when MUX_SCAN_PARITY_EN is defined
// Optional feature macro: MUX_SCAN_PARITY_EN.
module mux_scan_sampler
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1   // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [SEL_W-1:0]  sel,
    input  logic              mux_out,
    output logic [NUM_CH-1:0] word,
    output logic              valid,
    input  logic              ready,
    output logic              busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              parity
`endif
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

    state_t            state;
    logic              launch;
    logic              ctr_load;
    logic              ctr_en;
    logic              ctr_tc;
    logic [NUM_CH-1:0] word_nxt;

    // A scan begins from IDLE, or straight out of DONE when the consumer
    // accepts the word and asks for another one on the same edge.
    assign launch   = start && ((state == IDLE) || ((state == DONE) && ready));
    assign ctr_load = launch || ((state == SAMPLE) && (sel != LAST_SEL));
    assign ctr_en   = (state == SETTLE) && !ctr_tc;

    // NOTE: give every always_comb output a full default first; a path that
    // leaves it unassigned would infer a latch.
    always_comb begin
        word_nxt      = word;
        word_nxt[sel] = mux_out;
    end

    mux_scan_settle_ctr #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (ctr_load),
        .en   (ctr_en),
        .tc   (ctr_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            word   <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // sel keeps its last value while idle
                    if (launch) begin
                        state <= SETTLE;
                        sel   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (ctr_tc) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    // Unsampled bits keep the previous scan's values.
                    word   <= word_nxt;
`ifdef MUX_SCAN_PARITY_EN
                    parity <= ^word_nxt;
`endif
                    if (sel == LAST_SEL) begin
                        state <= DONE;
                        valid <= 1'b1;
                    end else begin
                        sel   <= sel + SEL_W'(1);
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (launch) begin
                            state <= SETTLE;
                            sel   <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
